// File: rtl/array_pkg.sv
// Shared types and helpers for the systolic-array job scheduler and its skew feeder.
package array_pkg;

   localparam int ARR_N  = 4;
   localparam int ARR_DW = 8;

   typedef enum logic [2:0] {IDLE, FILL, KICK, WLOAD, FEED, DRAIN} sched_state_e;

   // Sample index presented on activation lane i at feed cycle t (diagonal skew).
   function automatic int skew_idx(input int t, input int i);
      return t - i;
   endfunction

endpackage

// File: rtl/array_skew_feeder.sv
// Activation buffer for one job; drives the diagonally skewed activation lanes from the feed counter.
module array_skew_feeder
   import array_pkg::*;
#(
   parameter int  N  = ARR_N,
   parameter int  DW = ARR_DW,
   localparam int TW = $clog2(4*N) + 1,
   localparam int RW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a_we,
   input  logic [RW-1:0]   a_row,
   input  logic [N*DW-1:0] a_data,
   input  logic            feed_en,
   input  logic [TW-1:0]   t,
   output logic [N*DW-1:0] arr_a
);

   logic [N*DW-1:0] a_buf [N];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int m = 0; m < N; m++) a_buf[m] <= '0;
      end else if (a_we) begin
         a_buf[a_row] <= a_data;
      end
   end

   // Index is held signed in TW bits so lanes ahead of or behind the wavefront read as zero.
   always_comb begin
      logic signed [TW-1:0] d;
      d     = '0;
      arr_a = '0;
      for (int i = 0; i < N; i++) begin
         d = TW'(skew_idx(int'(t), i));
         if (feed_en && d >= 0 && d <= N - 1)
            arr_a[i*DW +: DW] = a_buf[d[RW-1:0]][i*DW +: DW];
      end
   end

endmodule

// File: rtl/array_job_scheduler.sv
// Sequences one N x N job through the weight-stationary array: buffer W/A, load, feed, capture, stream out.
// Optional perf counters (perf_jobs, perf_stall) are built when ARRAY_SCHED_PERF_EN is defined.
module array_job_scheduler
   import array_pkg::*;
#(
   parameter int N        = ARR_N,
   parameter int DW       = ARR_DW,
   parameter int Y_OFFSET = N
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [N*DW-1:0] res_data,
   output logic            res_last,
   input  logic            arr_ready,
   input  logic            arr_done,
   output logic            arr_start,
   output logic [N*DW-1:0] arr_w,
   output logic [N*DW-1:0] arr_a,
   input  logic [N*DW-1:0] arr_y,
   output logic            busy
`ifdef ARRAY_SCHED_PERF_EN
   ,
   output logic [31:0]     perf_jobs,
   output logic [31:0]     perf_stall
`endif
);

   localparam int TW = $clog2(4*N) + 1;
   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(2*N) + 1;

   sched_state_e    state_q, state_d;
   logic            run_q;
   logic [CW-1:0]   cnt_q;
   logic [RW-1:0]   c_q;
   logic [TW-1:0]   t_q;
   logic [RW-1:0]   r_q;
   logic [N*DW-1:0] w_buf   [N];
   logic [N*DW-1:0] res_buf [N];
   logic            accept;

   assign accept = in_valid & in_ready;
   assign busy   = (state_q != IDLE);

   // run_q keeps in_ready low while reset is held and for the first cycle after release.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      arr_start = 1'b0;
      arr_w     = '0;
      res_valid = 1'b0;
      res_data  = '0;
      res_last  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = run_q;
            if (in_valid && run_q) state_d = FILL;
         end
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && cnt_q == CW'(2*N - 1)) state_d = KICK;
         end
         KICK: begin
            arr_start = arr_ready;
            if (arr_ready) state_d = WLOAD;
         end
         WLOAD: begin
            arr_w = w_buf[RW'(N - 1) - c_q];
            if (c_q == RW'(N - 1)) state_d = FEED;
         end
         FEED: begin
            if (arr_done) state_d = DRAIN;
         end
         DRAIN: begin
            res_valid = 1'b1;
            res_data  = res_buf[r_q];
            res_last  = (r_q == RW'(N - 1));
            if (res_ready && r_q == RW'(N - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
         cnt_q   <= '0;
         c_q     <= '0;
         t_q     <= '0;
         r_q     <= '0;
         for (int m = 0; m < N; m++) begin
            w_buf[m]   <= '0;
            res_buf[m] <= '0;
         end
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         case (state_q)
            IDLE: if (accept) begin
               w_buf[0] <= in_data;
               cnt_q    <= CW'(1);
            end
            FILL: if (accept) begin
               if (cnt_q < CW'(N)) w_buf[RW'(cnt_q)] <= in_data;
               cnt_q <= (cnt_q == CW'(2*N - 1)) ? '0 : cnt_q + CW'(1);
            end
            KICK: c_q <= '0;
            WLOAD: begin
               c_q <= c_q + RW'(1);
               // Fresh result buffer per job so entries the array never reaches read as zero.
               if (c_q == RW'(N - 1)) begin
                  t_q <= '0;
                  for (int m = 0; m < N; m++) res_buf[m] <= '0;
               end
            end
            FEED: begin
               if (t_q != TW'(4*N - 1)) t_q <= t_q + TW'(1);
               for (int m = 0; m < N; m++)
                  for (int j = 0; j < N; j++)
                     if (t_q == TW'(Y_OFFSET + m + j))
                        res_buf[m][j*DW +: DW] <= arr_y[j*DW +: DW];
               if (arr_done) r_q <= '0;
            end
            DRAIN: if (res_ready) r_q <= r_q + RW'(1);
            default: ;
         endcase
      end
   end

   array_skew_feeder #(.N(N), .DW(DW)) u_feeder (
      .clk     (clk),
      .rst     (rst),
      .a_we    (accept && cnt_q >= CW'(N)),
      .a_row   (RW'(cnt_q - CW'(N))),
      .a_data  (in_data),
      .feed_en (state_q == FEED),
      .t       (t_q),
      .arr_a   (arr_a)
   );

`ifdef ARRAY_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_jobs  <= '0;
         perf_stall <= '0;
      end else begin
         if (state_q == DRAIN && res_ready && res_last) perf_jobs <= perf_jobs + 32'd1;
         if ((state_q == KICK && !arr_ready) || (state_q == DRAIN && !res_ready))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_array_job_scheduler.sv
// Scoreboard bench for array_job_scheduler with a stub array that answers arr_y = lane + 16*t.
module tb_array_job_scheduler;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int LW = N*DW;

   typedef struct packed {
      logic [LW-1:0] data;
      logic          last;
   } row_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid, in_ready, res_valid, res_ready, res_last;
   logic          arr_ready, arr_done, arr_start, busy;
   logic [LW-1:0] in_data, res_data, arr_w, arr_a, arr_y;
`ifdef ARRAY_SCHED_PERF_EN
   logic [31:0]   perf_jobs, perf_stall;
`endif

   row_t          sb[$];
   row_t          mon_e;
   int            n_vec = 0;
   int            n_err = 0;
   int            exp_stall = 0;
   int            sk = -1;
   logic          hold = 1'b0;
   logic [LW-1:0] cur_w [N];
   logic [LW-1:0] cur_a [N];
   logic [LW-1:0] prev_res = '0;
   logic          prev_stall = 1'b0;

   always #5 clk = ~clk;

   array_job_scheduler #(.N(N), .DW(DW), .Y_OFFSET(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_last  (res_last),
      .arr_ready (arr_ready),
      .arr_done  (arr_done),
      .arr_start (arr_start),
      .arr_w     (arr_w),
      .arr_a     (arr_a),
      .arr_y     (arr_y),
      .busy      (busy)
`ifdef ARRAY_SCHED_PERF_EN
      ,
      .perf_jobs  (perf_jobs),
      .perf_stall (perf_stall)
`endif
   );

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Stub array: sk counts cycles since the accepted start; feed cycle t = sk - N; done at t = 3N-1.
   always @(posedge clk or negedge rst) begin
      if (!rst)                       sk <= -1;
      else if (arr_start && arr_ready) sk <= 0;
      else if (sk == 4*N - 1)          sk <= -1;
      else if (sk >= 0)                sk <= sk + 1;
   end
   assign arr_ready = !hold && (sk < 0);
   assign arr_done  = (sk == 4*N - 1);
   always_comb begin
      arr_y = '0;
      for (int j = 0; j < N; j++) arr_y[j*DW +: DW] = DW'(j + 16*(sk - N));
   end

   function automatic logic [LW-1:0] exp_a(input int t);
      logic [LW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) v[i*DW +: DW] = cur_a[t-i][i*DW +: DW];
      return v;
   endfunction

   function automatic logic [LW-1:0] exp_row(input int m);
      logic [LW-1:0] v;
      v = '0;
      for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(j + 16*(N + m + j));
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (sk >= 0 && sk < N) begin
            chk("wload_w", arr_w, cur_w[N-1-sk]);
            chk("wload_a", arr_a, '0);
         end
         if (sk >= N) begin
            chk("feed_a", arr_a, exp_a(sk - N));
            chk("feed_w", arr_w, '0);
         end
         if (!arr_ready) chk("start_gated", LW'(arr_start), '0);
         if (sb.size() == 0) begin
            chk("res_unexpected", LW'(res_valid), '0);
         end else if (res_valid) begin
            chk("in_ready_drain", LW'(in_ready), '0);
            if (prev_stall) chk("res_hold", res_data, prev_res);
            if (res_ready) begin
               mon_e = sb.pop_front();
               chk("res_data", res_data, mon_e.data);
               chk("res_last", LW'(res_last), LW'(mon_e.last));
            end
         end
         prev_stall = res_valid && !res_ready;
         prev_res   = res_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_in_ready"},  LW'(in_ready),  '0);
      chk({pfx, "_res_valid"}, LW'(res_valid), '0);
      chk({pfx, "_res_last"},  LW'(res_last),  '0);
      chk({pfx, "_arr_start"}, LW'(arr_start), '0);
      chk({pfx, "_arr_w"},     arr_w,          '0);
      chk({pfx, "_arr_a"},     arr_a,          '0);
      chk({pfx, "_busy"},      LW'(busy),      '0);
   endtask

   task automatic send_beat(input logic [LW-1:0] d);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("beat_accept", LW'(ok), LW'(1));
   endtask

   task automatic send_job(input bit gaps);
      row_t e;
      for (int m = 0; m < N; m++) begin
         e.data = exp_row(m);
         e.last = (m == N - 1);
         sb.push_back(e);
      end
      for (int b = 0; b < 2*N; b++) begin
         if (gaps && (b % 3 == 1)) begin
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
         end
         send_beat(b < N ? cur_w[b] : cur_a[b-N]);
      end
   endtask

   task automatic wait_done();
      for (int k = 0; k < 400 && sb.size() > 0; k++) @(posedge clk);
      #1;
      chk("job_done", LW'(sb.size()), '0);
   endtask

   task automatic random_job();
      for (int m = 0; m < N; m++) begin
         cur_w[m] = LW'($urandom());
         cur_a[m] = LW'($urandom());
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      res_ready = 1'b1;
      #1;
      chk_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_in_ready", LW'(in_ready), LW'(1));
      chk("idle_busy",     LW'(busy),     '0);

      // Identity weights, A[m][k] = 10m+k.
      for (int m = 0; m < N; m++) begin
         cur_w[m] = '0;
         cur_w[m][m*DW +: DW] = DW'(1);
         for (int k = 0; k < N; k++) cur_a[m][k*DW +: DW] = DW'(10*m + k);
      end
      send_job(1'b0);
      wait_done();

      // Abort mid-feed at t=5.
      random_job();
      send_job(1'b1);
      for (int k = 0; k < 400 && sk != N + 5; k++) @(negedge clk);
      chk("abort_reached", LW'(sk), LW'(N + 5));
      #1 rst = 1'b0;
      sb.delete();
      #1;
      chk_reset_outputs("abort");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Array busy for 7 KICK cycles, then downstream stalls 5 DRAIN cycles.
      random_job();
      hold      = 1'b1;
      res_ready = 1'b0;
      send_job(1'b0);
      repeat (7) @(posedge clk);
      #1 hold = 1'b0;
      exp_stall += 7;
      for (int k = 0; k < 400 && !res_valid; k++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_reached", LW'(res_valid), LW'(1));
      repeat (5) @(posedge clk);
      #1 res_ready = 1'b1;
      exp_stall += 5;

      // Queued behind the stalled job; accepted once it drains.
      random_job();
      send_job(1'b0);
      wait_done();
      repeat (2) @(posedge clk);
      #1;
      chk("end_busy", LW'(busy), '0);
`ifdef ARRAY_SCHED_PERF_EN
      chk("perf_jobs",  LW'(perf_jobs),  LW'(2));
      chk("perf_stall", LW'(perf_stall), LW'(exp_stall));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
